// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew codes and
// forwarding-select values common to the D-stage and E-stage selectors.
package hazard_pkg;

    localparam int TUSE_NONE = 3;

    localparam int TNEW_E    = 0;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LOAD = 2;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

    // The E-stage operand muxes call "no forward" the pipelined value, not the RF.
    localparam fwd_sel_e FWD_PIPE = FWD_RF;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding priority selector: youngest matching producer wins,
// and a producer whose result is not yet ready blocks older stages.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int TW     = 2,
    parameter bit HAS_E  = 1'b1
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] e_a3,
    input  logic [TW-1:0]     e_tnew,
    input  logic [REG_AW-1:0] m_a3,
    input  logic [TW-1:0]     m_tnew,
    input  logic [REG_AW-1:0] w_a3,
    output logic [1:0]        sel
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        sel = FWD_RF;
        if (src == '0) begin
            sel = FWD_RF;
        end else if (HAS_E && (e_a3 == src)) begin
            sel = (e_tnew == '0) ? FWD_E : FWD_RF;
        end else if (m_a3 == src) begin
            sel = (m_tnew == '0) ? FWD_M : FWD_RF;
        end else if (w_a3 == src) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: shadow pipeline of destinations and Tnew for
// E/M/W, D-stage stall/bubble decision and D/E forwarding selects.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int TW     = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic [TW-1:0]     D_Tuse_rs,
    input  logic [TW-1:0]     D_Tuse_rt,
    input  logic [REG_AW-1:0] D_A3,
    input  logic [TW-1:0]     D_Tnew,
    output logic              stall,
    output logic [1:0]        D_fwd_rs,
    output logic [1:0]        D_fwd_rt,
    output logic [1:0]        E_fwd_rs,
    output logic [1:0]        E_fwd_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_AW-1:0] e_a3_q, e_a3_d;
    logic [TW-1:0]     e_tnew_q, e_tnew_d;
    logic [REG_AW-1:0] e_rs_q, e_rs_d;
    logic [REG_AW-1:0] e_rt_q, e_rt_d;
    logic [REG_AW-1:0] m_a3_q, m_a3_d;
    logic [TW-1:0]     m_tnew_q, m_tnew_d;
    logic [REG_AW-1:0] w_a3_q, w_a3_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic hazard_rs, hazard_rt;

    // A D operand must wait while E or M holds its producer and the result
    // will not exist before the operand is consumed; W is always ready.
    always_comb begin
        hazard_rs = (D_rs != '0) && (D_Tuse_rs != TW'(TUSE_NONE)) &&
                    (((e_a3_q == D_rs) && (e_tnew_q > D_Tuse_rs)) ||
                     ((m_a3_q == D_rs) && (m_tnew_q > D_Tuse_rs)));
        hazard_rt = (D_rt != '0) && (D_Tuse_rt != TW'(TUSE_NONE)) &&
                    (((e_a3_q == D_rt) && (e_tnew_q > D_Tuse_rt)) ||
                     ((m_a3_q == D_rt) && (m_tnew_q > D_Tuse_rt)));
        stall     = hazard_rs | hazard_rt;
    end

    always_comb begin
        w_a3_d      = m_a3_q;
        m_a3_d      = e_a3_q;
        m_tnew_d    = (e_tnew_q == '0) ? '0 : e_tnew_q - 1'b1;
        e_a3_d      = D_A3;
        e_tnew_d    = D_Tnew;
        e_rs_d      = D_rs;
        e_rt_d      = D_rt;
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            e_a3_d   = '0;
            e_tnew_d = '0;
            e_rs_d   = '0;
            e_rt_d   = '0;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            e_a3_q      <= '0;
            e_tnew_q    <= '0;
            e_rs_q      <= '0;
            e_rt_q      <= '0;
            m_a3_q      <= '0;
            m_tnew_q    <= '0;
            w_a3_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_a3_q      <= e_a3_d;
            e_tnew_q    <= e_tnew_d;
            e_rs_q      <= e_rs_d;
            e_rt_q      <= e_rt_d;
            m_a3_q      <= m_a3_d;
            m_tnew_q    <= m_tnew_d;
            w_a3_q      <= w_a3_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW), .HAS_E(1'b1)) u_d_rs_sel (
        .src(D_rs), .e_a3(e_a3_q), .e_tnew(e_tnew_q),
        .m_a3(m_a3_q), .m_tnew(m_tnew_q), .w_a3(w_a3_q), .sel(D_fwd_rs)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW), .HAS_E(1'b1)) u_d_rt_sel (
        .src(D_rt), .e_a3(e_a3_q), .e_tnew(e_tnew_q),
        .m_a3(m_a3_q), .m_tnew(m_tnew_q), .w_a3(w_a3_q), .sel(D_fwd_rt)
    );

    // E-stage operands only look at M and W; the E producer is themselves.
    hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW), .HAS_E(1'b0)) u_e_rs_sel (
        .src(e_rs_q), .e_a3('0), .e_tnew('0),
        .m_a3(m_a3_q), .m_tnew(m_tnew_q), .w_a3(w_a3_q), .sel(E_fwd_rs)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW), .HAS_E(1'b0)) u_e_rt_sel (
        .src(e_rt_q), .e_a3('0), .e_tnew('0),
        .m_a3(m_a3_q), .m_tnew(m_tnew_q), .w_a3(w_a3_q), .sel(E_fwd_rt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline.
- Keeps a shadow pipeline of destination register and Tnew for each in-flight instruction (E, M, W), plus the E-stage source registers.
- Each cycle it decides the D-stage stall, bubble insertion into E, and the forwarding selects for the D-stage comparator operands and the E-stage ALU operands.
- Sits beside the D-stage register file and comparator. It owns all stall/forward sequencing so the datapath stays purely combinational.

Parameters:
- REG_AW, 5, register-address width.
- TW, 2, Tnew/Tuse width; Tuse value 3 means "operand not used".
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- D_rs  in  REG_AW  D-stage source register 1
- D_rt  in  REG_AW  D-stage source register 2
- D_Tuse_rs  in  TW  cycles until rs is needed (0 = needed in D, e.g. branch compare; 3 = unused)
- D_Tuse_rt  in  TW  same for rt
- D_A3  in  REG_AW  D-stage destination (0 = no write)
- D_Tnew  in  TW  cycles after entering E until result exists (0 = available in E, 1 = end of E, 2 = end of M)
- stall  out  1  freeze PC and F/D register; bubble into D/E register
- D_fwd_rs  out  2  D operand-1 source: 0 = RF, 1 = W, 2 = M, 3 = E
- D_fwd_rt  out  2  same for operand 2
- E_fwd_rs  out  2  E operand-1 source: 0 = pipelined register value, 1 = W, 2 = M (3 unused)
- E_fwd_rt  out  2  same for operand 2
- stall_cnt  out  CNT_W  number of stall cycles since reset

Behaviour:
- State registers:
  - E_A3, E_Tnew, E_rs, E_rt
  - M_A3, M_Tnew
  - W_A3
  - stall_cnt
- Reset (synchronous, reset=1 at posedge): all state registers cleared to 0. All outputs are then 0: stall=0, all fwd=0, stall_cnt=0.
- Advance at every posedge when reset=0:
  - W_A3 <= M_A3.
  - M_A3 <= E_A3; M_Tnew <= E_Tnew==0 ? 0 : E_Tnew-1 (saturating at 0).
  - If stall=1: E_A3 <= 0, E_Tnew <= 0, E_rs <= 0, E_rt <= 0 (bubble).
  - Else: E_A3 <= D_A3, E_Tnew <= D_Tnew, E_rs <= D_rs, E_rt <= D_rt.
- Stall (combinational from current state and D inputs), evaluated per operand x in {rs, rt}:
  - hazard_x = (D_x != 0) && (D_Tuse_x != 3) && ((E_A3 == D_x && E_Tnew > D_Tuse_x) || (M_A3 == D_x && M_Tnew > D_Tuse_x)).
  - stall = hazard_rs | hazard_rt.
- W never causes a stall.
- D forwarding per operand, in priority order:
  - 0 if D_x == 0.
  - else 3 if E_A3 == D_x && E_Tnew == 0.
  - else 2 if M_A3 == D_x && M_Tnew == 0.
  - else 1 if W_A3 == D_x.
  - else 0.
  - A matching younger stage with Tnew > 0 blocks fallthrough to older stages: fwd = 0 and stall is asserted. Selects are don't-care while stall=1, but must still be deterministic.
- E forwarding per operand:
  - 0 if E_x == 0.
  - else 2 if M_A3 == E_x && M_Tnew == 0.
  - else 1 if W_A3 == E_x.
  - else 0.
  - E never stalls: the D-stage stall rule guarantees readiness.
- Register 0: never forwarded, never stalls, even when a stage has A3 = 0.
- stall_cnt increments by 1 on every non-reset posedge with stall=1. It saturates at all-ones with no wrap.
- Reset mid-stall: the next cycle shows all stages empty and stall=0.
- Back-to-back stalls: a load-to-branch dependence (Tnew=2, Tuse=0) yields exactly 2 stall cycles. A load-to-ALU dependence (Tuse=1) yields exactly 1.

Decomposition:
- Shared package holds:
  - TUSE_NONE = 3
  - Tnew encodings: TNEW_E = 0, TNEW_ALU = 1, TNEW_LOAD = 2
  - Forward-select encodings: FWD_RF/PIPE = 0, FWD_W = 1, FWD_M = 2, FWD_E = 3
- One natural sub-module: hazard_fwd_sel. It is the combinational per-operand priority selector and is instantiated 4 times, for D_rs, D_rt, E_rs and E_rt.

Test Plan:
- Reset held 2 cycles with random D inputs -> stall=0, all fwd=0, stall_cnt=0 on release.
- Load (D_A3=8, D_Tnew=2), then beq with D_rs=8, D_Tuse_rs=0 -> stall=1 for 2 cycles; then D_fwd_rs=1 (W); stall_cnt=2.
- ALU write $9 (Tnew=1), then add using $9 (Tuse=1) -> no stall; next cycle E_fwd_rs=2 (M).
- ALU write $10 (Tnew=1), then beq on $10 (Tuse=0) -> 1 stall; then D_fwd_rs=2 (M).
- Write $0 with Tnew=2, then beq $0,$0 (Tuse=0) -> stall=0, D_fwd_rs=D_fwd_rt=0.
- jal-type write $31 (Tnew=0), then jr $31 (Tuse=0) -> no stall, D_fwd_rs=3 (E). Reset asserted during a load-induced stall -> stall=0 the following cycle.
